// File: rtl/riscv_i32_trace_sequencer_if.sv
// RISC-V i32 retirement trace bundle.
// The CPU drives it through the master modport; the trace sequencer samples it through the slave modport.
interface riscv_i32_trace_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap;

  modport master (output instr_valid, instr_pc, branch_taken, branch_target, trap);
  modport slave  (input  instr_valid, instr_pc, branch_taken, branch_target, trap);
endinterface

// File: rtl/riscv_i32_trace_sequencer.sv
// Filters retired instructions into trace records, buffers them and streams each record as a word burst.
// Optional RISCV_I32_TRACE_SEQ_TIMESTAMP_EN adds a cycle timestamp word per record (header tag 0xB).
module riscv_i32_trace_sequencer #(
  parameter int FIFO_LOG2 = 3
) (
  input  logic                              clk,
  input  logic                              clk__enable,
  input  logic                              reset,
  riscv_i32_trace_sequencer_if.slave        trace,
  input  logic                              capture_enable,
  input  logic                              capture_all,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       out_data,
  output logic [FIFO_LOG2:0]                fifo_count,
  output logic                              overflow,
  input  logic                              overflow_clear
);

  localparam int                   DEPTH      = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   COUNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   COUNT_ONE  = 1;
  localparam logic [FIFO_LOG2-1:0] PTR_ONE    = 1;
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
  localparam logic [3:0]           HDR_TAG    = 4'hB;
`else
  localparam logic [3:0]           HDR_TAG    = 4'hA;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_TGT
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
    , S_TS
`endif
  } state_t;

  function automatic logic [1:0] rec_kind(input logic is_trap, input logic is_branch);
    if (is_trap)        return 2'b10;
    else if (is_branch) return 2'b01;
    else                return 2'b00;
  endfunction

  function automatic logic [9:0] sat_inc_drops(input logic [9:0] d);
    return (d == 10'h3FF) ? d : d + 10'd1;
  endfunction

  state_t                 state, next_state;
  logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [15:0]            seq;
  logic [9:0]             drop_count;
  logic                   capture, full, push, drop, pop, last_word, more;
  logic [1:0]             kind_new;
  logic [31:0]            target_new;

  logic [1:0]             kind_mem  [DEPTH];
  logic [15:0]            seq_mem   [DEPTH];
  logic [9:0]             drops_mem [DEPTH];
  logic [31:0]            pc_mem    [DEPTH];
  logic [31:0]            tgt_mem   [DEPTH];
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
  logic [31:0]            cycle_count;
  logic [31:0]            ts_mem    [DEPTH];
`endif

  assign capture    = clk__enable & capture_enable & trace.instr_valid &
                      (capture_all | trace.branch_taken | trace.trap);
  assign full       = (fifo_count == COUNT_FULL);
  // A full FIFO drops the record even when the head pops in the same cycle.
  assign push       = capture & ~full;
  assign drop       = capture & full;
  assign kind_new   = rec_kind(trace.trap, trace.branch_taken);
  assign target_new = (kind_new == 2'b01) ? trace.branch_target : 32'h0;
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
  assign last_word  = (state == S_TS);
`else
  assign last_word  = (state == S_TGT);
`endif
  assign pop        = clk__enable & out_valid & out_ready & last_word;
  assign more       = (fifo_count > COUNT_ONE) | push;

  // Record storage: written at push, read at the head pointer during serialisation
  always_ff @(posedge clk) begin
    if (push) begin
      kind_mem[wr_ptr]  <= kind_new;
      seq_mem[wr_ptr]   <= seq;
      drops_mem[wr_ptr] <= drop_count;
      pc_mem[wr_ptr]    <= trace.instr_pc;
      tgt_mem[wr_ptr]   <= target_new;
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
      ts_mem[wr_ptr]    <= cycle_count;
`endif
    end
  end

  // FIFO bookkeeping, sequence/drop counters and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      seq         <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
      cycle_count <= '0;
`endif
    end else if (clk__enable) begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        seq        <= seq + 16'd1;
        drop_count <= '0;
      end else if (drop) begin
        drop_count <= sat_inc_drops(drop_count);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        fifo_count <= fifo_count + COUNT_ONE;
      else if (pop && !push)
        fifo_count <= fifo_count - COUNT_ONE;
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clear)
        overflow <= 1'b0;
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
      cycle_count <= cycle_count + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else if (clk__enable)
      state <= next_state;
  end

  // Leaving IDLE on the push itself gives the header in the cycle after capture.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    out_data   = 32'h0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0 || push)
          next_state = S_HDR;
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = {HDR_TAG, kind_mem[rd_ptr], drops_mem[rd_ptr], seq_mem[rd_ptr]};
        if (out_ready)
          next_state = S_PC;
      end
      S_PC: begin
        out_valid = 1'b1;
        out_data  = pc_mem[rd_ptr];
        if (out_ready)
          next_state = S_TGT;
      end
      S_TGT: begin
        out_valid = 1'b1;
        out_data  = tgt_mem[rd_ptr];
        if (out_ready) begin
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
          next_state = S_TS;
`else
          next_state = more ? S_HDR : S_IDLE;
`endif
        end
      end
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
      S_TS: begin
        out_valid = 1'b1;
        out_data  = ts_mem[rd_ptr];
        if (out_ready)
          next_state = more ? S_HDR : S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_i32_trace_sequencer.sv
// Directed bench for riscv_i32_trace_sequencer with hand-computed trace words.
module tb_riscv_i32_trace_sequencer;
  localparam int FIFO_LOG2 = 3;

  logic                 clk = 1'b0;
  logic                 clk_en;
  logic                 reset;
  logic                 capture_enable;
  logic                 capture_all;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [FIFO_LOG2:0]   fifo_count;
  logic                 overflow;
  logic                 overflow_clear;

  int vectors     = 0;
  int miscompares = 0;

  riscv_i32_trace_sequencer_if trace();

  riscv_i32_trace_sequencer #(.FIFO_LOG2(FIFO_LOG2)) dut (
    .clk            (clk),
    .clk__enable    (clk_en),
    .reset          (reset),
    .trace          (trace),
    .capture_enable (capture_enable),
    .capture_all    (capture_all),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic br, input logic [31:0] tgt, input logic tr);
    trace.instr_valid   = 1'b1;
    trace.instr_pc      = pc;
    trace.branch_taken  = br;
    trace.branch_target = tgt;
    trace.trap          = tr;
    next_cycle();
    trace.instr_valid   = 1'b0;
    trace.branch_taken  = 1'b0;
    trace.trap          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); miscompares++;
    end
    vectors++;
    if (out_data !== 32'h0) begin
      $display("FAIL reset_out_data: got %h expected 00000000", out_data); miscompares++;
    end
    vectors++;
    if (fifo_count !== '0) begin
      $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); miscompares++;
    end
    vectors++;
    if (overflow !== 1'b0) begin
      $display("FAIL reset_overflow: got %b expected 0", overflow); miscompares++;
    end
    next_cycle();
  endtask

  task automatic test_branch_capture();
    logic [31:0] exp [3];
    exp = '{32'hA400_0000, 32'h0000_0100, 32'h0000_0200};
    capture_enable = 1'b1;
    capture_all    = 1'b0;
    out_ready      = 1'b1;
    retire(32'h100, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        $display("FAIL branch_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp[i]);
        miscompares++;
      end
      if (i == 0) begin
        vectors++;
        if (fifo_count !== 4'd1) begin
          $display("FAIL branch_count_busy: got %0d expected 1", fifo_count); miscompares++;
        end
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL branch_done: got v=%b count=%0d expected v=0 count=0", out_valid, fifo_count);
      miscompares++;
    end
    next_cycle();
  endtask

  task automatic test_filtering();
    logic [31:0] exp_all [3];
    logic [31:0] exp_trap [3];
    exp_all  = '{32'hA000_0001, 32'h0000_0108, 32'h0000_0000};
    exp_trap = '{32'hA800_0002, 32'h0000_010C, 32'h0000_0000};
    retire(32'h104, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL filter_plain: got v=%b count=%0d expected v=0 count=0", out_valid, fifo_count);
      miscompares++;
    end
    next_cycle();
    capture_all = 1'b1;
    retire(32'h108, 1'b0, 32'hDEAD_0000, 1'b0);
    capture_all = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_all[i]) begin
        $display("FAIL capture_all_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp_all[i]);
        miscompares++;
      end
      next_cycle();
    end
    retire(32'h10C, 1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_trap[i]) begin
        $display("FAIL trap_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp_trap[i]);
        miscompares++;
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL trap_done: got v=%b expected 0", out_valid); miscompares++;
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    logic [31:0] exp_new [3];
    exp_new = '{32'hA403_000B, 32'h0000_3000, 32'h0000_3004};
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++)
      retire(32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(4 * i), 1'b0);
    @(negedge clk);
    vectors++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      $display("FAIL overflow_fill: got count=%0d ovf=%b expected count=8 ovf=1", fifo_count, overflow);
      miscompares++;
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hA400_0003) begin
      $display("FAIL overflow_head: got v=%b %h expected v=1 a4000003", out_valid, out_data);
      miscompares++;
    end
    next_cycle();
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int w = 0; w < 3; w++) begin
        case (w)
          0:       exp = 32'hA400_0000 | 32'(3 + j);
          1:       exp = 32'h1000 + 32'(4 * j);
          default: exp = 32'h2000 + 32'(4 * j);
        endcase
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          $display("FAIL drain_rec%0d_word%0d: got v=%b %h expected v=1 %h", j, w, out_valid, out_data, exp);
          miscompares++;
        end
        next_cycle();
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL drain_done: got v=%b count=%0d expected v=0 count=0", out_valid, fifo_count);
      miscompares++;
    end
    next_cycle();
    retire(32'h3000, 1'b1, 32'h3004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_new[i]) begin
        $display("FAIL post_drop_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp_new[i]);
        miscompares++;
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1) begin
      $display("FAIL overflow_sticky: got %b expected 1", overflow); miscompares++;
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [6];
    logic [31:0] prev_data;
    logic        have_prev;
    int          k;
    exp = '{32'hA400_000C, 32'h0000_0500, 32'h0000_0600,
            32'hA800_000D, 32'h0000_0504, 32'h0000_0000};
    out_ready = 1'b0;
    retire(32'h500, 1'b1, 32'h600, 1'b0);
    retire(32'h504, 1'b0, 32'h0, 1'b1);
    k = 0;
    have_prev = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (have_prev) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          $display("FAIL stall_stable: got v=%b %h expected v=1 %h", out_valid, out_data, prev_data);
          miscompares++;
        end
        have_prev = 1'b0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (out_data !== exp[k] || fifo_count !== 4'((k < 3) ? 2 : 1)) begin
          $display("FAIL bp_word%0d: got %h count=%0d expected %h count=%0d",
                   k, out_data, fifo_count, exp[k], (k < 3) ? 2 : 1);
          miscompares++;
        end
        k++;
      end else if (out_valid === 1'b1) begin
        have_prev = 1'b1;
        prev_data = out_data;
      end
      next_cycle();
    end
    vectors++;
    if (k != 6) begin
      $display("FAIL bp_word_count: got %0d expected 6", k); miscompares++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL bp_done: got v=%b count=%0d expected v=0 count=0", out_valid, fifo_count);
      miscompares++;
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp [3];
    exp = '{32'hA400_0000, 32'h0000_0900, 32'h0000_0904};
    out_ready      = 1'b0;
    overflow_clear = 1'b1;
    next_cycle();
    overflow_clear = 1'b0;
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clear: got %b expected 0", overflow); miscompares++;
    end
    next_cycle();
    for (int i = 0; i < 8; i++)
      retire(32'h700 + 32'(4 * i), 1'b1, 32'h780 + 32'(4 * i), 1'b0);
    @(negedge clk);
    vectors++;
    if (fifo_count !== 4'd8) begin
      $display("FAIL sim_fill: got %0d expected 8", fifo_count); miscompares++;
    end
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    next_cycle();
    overflow_clear = 1'b1;
    retire(32'h7F0, 1'b1, 32'h7F4, 1'b0);
    overflow_clear = 1'b0;
    @(negedge clk);
    vectors++;
    if (fifo_count !== 4'd7) begin
      $display("FAIL full_push_pop_count: got %0d expected 7", fifo_count); miscompares++;
    end
    vectors++;
    if (overflow !== 1'b1) begin
      $display("FAIL clear_vs_drop: got %b expected 1", overflow); miscompares++;
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hA400_000F) begin
      $display("FAIL next_head: got v=%b %h expected v=1 a400000f", out_valid, out_data);
      miscompares++;
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (out_data !== 32'h0000_0704) begin
      $display("FAIL pre_reset_pc: got %h expected 00000704", out_data); miscompares++;
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0 || out_data !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL midburst_reset: got v=%b count=%0d data=%h ovf=%b expected v=0 count=0 data=0 ovf=0",
               out_valid, fifo_count, out_data, overflow);
      miscompares++;
    end
    next_cycle();
    retire(32'h900, 1'b1, 32'h904, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        $display("FAIL after_reset_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp[i]);
        miscompares++;
      end
      next_cycle();
    end
  endtask

  task automatic test_timestamp();
    logic [31:0] exp [4];
    exp = '{32'hB400_0000, 32'h0000_0040, 32'h0000_0044, 32'h0000_0005};
    capture_enable = 1'b1;
    capture_all    = 1'b0;
    out_ready      = 1'b1;
    for (int i = 0; i < 4; i++)
      next_cycle();
    retire(32'h40, 1'b1, 32'h44, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        $display("FAIL ts_word%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp[i]);
        miscompares++;
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL ts_done: got v=%b count=%0d expected v=0 count=0", out_valid, fifo_count);
      miscompares++;
    end
    next_cycle();
  endtask

  initial begin
    clk_en              = 1'b1;
    reset               = 1'b1;
    capture_enable      = 1'b0;
    capture_all         = 1'b0;
    out_ready           = 1'b0;
    overflow_clear      = 1'b0;
    trace.instr_valid   = 1'b0;
    trace.instr_pc      = '0;
    trace.branch_taken  = 1'b0;
    trace.branch_target = '0;
    trace.trap          = 1'b0;
    test_reset();
`ifdef RISCV_I32_TRACE_SEQ_TIMESTAMP_EN
    test_timestamp();
`else
    test_branch_capture();
    test_filtering();
    test_overflow();
    test_backpressure();
    test_simultaneous();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
